// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_e     - scanner FSM states
//   KEY_MAP     - 16-entry hex key map, nibble index = {row, col}
//   lowest_low  - index of the lowest-numbered low (pressed) row
//   key_code    - KEY_MAP lookup for a (row, col) pair
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // Rows (msb nibble group first): r3 = E,0,F,D  r2 = 7,8,9,C  r1 = 4,5,6,B  r0 = 1,2,3,A.
  // Within a group the rightmost nibble is col 0.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a WIDTH-bit bus, synchronous reset.
//   clk   - destination clock
//   reset - synchronous active-high reset, loads RESET_VAL into both stages
//   d     - asynchronous input bus
//   q     - synchronized output bus
module sync_2ff #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and single-key rollover.
//   clk       - system clock
//   reset     - synchronous active-high reset
//   rows      - keypad rows, active-low, asynchronous
//   cols      - column drive, one-hot-low
//   key       - hex code of the last accepted key
//   key_valid - one-cycle pulse on acceptance
//   key_held  - high from acceptance until debounced release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 24000,
  parameter int unsigned DEBOUNCE = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);

  logic [3:0]    rows_s;
  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          row_high;

  sync_2ff #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rows),
    .q    (rows_s)
  );

  assign row_high = rows_s[row_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // cnt_q is the column dwell timer in SCAN and the debounce timer elsewhere;
  // every state change clears it. Leaving a debounce state back to SCAN moves
  // on to the next column so a rejected/released key is not re-sampled at once.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rows_s != 4'hF) begin
            row_d   = lowest_low(rows_s);
            state_d = PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (row_high) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          key_d       = key_code(row_q, col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (row_high) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (!row_high) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          key_held_d = 1'b0;
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=8).
// A keypad model pulls a row low while a pressed key's column is driven low.
// Expected key codes are queued when a press is made; a monitor pops and
// compares them on every key_valid pulse.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;  // bit r*4+c = key at (row r, col c) pressed

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_key;

  typedef struct {
    logic        rst;
    logic [15:0] pressed;
    logic [3:0]  cols;
    logic        kv;
    logic        kh;
    logic [3:0]  key;
  } vec_t;

  vec_t vecs[18];

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (cols[c] == 1'b0)) rows[r] = 1'b0;
  end

  // Monitor samples at +1 so it always runs before the main sequence (+2).
  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got key %h, no key expected", key);
      end else begin
        exp_key = exp_q.pop_front();
        if (key !== exp_key) begin
          errors++;
          $display("FAIL key_on_pulse: got %h expected %h", key, exp_key);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns right after the edge on which column c becomes active.
  task automatic wait_col(input int c);
    logic [3:0] want;
    logic [3:0] prev;
    bit ok;
    want = ~(4'b0001 << c);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      prev = cols;
      tick();
      if (cols == want && prev != want) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("wait_col%0d", c), 32'(ok), 32'd1);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (key_valid === 1'b1) break;
    end
  endtask

  task automatic wait_held_low(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (key_held === 1'b0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;

    // {rst, pressed, cols, key_valid, key_held, key}: two reset cycles, then a
    // full scan lap with no key pressed (4 cycles per column).
    vecs[0]  = '{1'b1, 16'h0000, 4'b1110, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 16'h0000, 4'b1110, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0, 4'h0};
    vecs[5]  = '{1'b0, 16'h0000, 4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[6]  = '{1'b0, 16'h0000, 4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[7]  = '{1'b0, 16'h0000, 4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 16'h0000, 4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 16'h0000, 4'b1011, 1'b0, 1'b0, 4'h0};
    vecs[10] = '{1'b0, 16'h0000, 4'b1011, 1'b0, 1'b0, 4'h0};
    vecs[11] = '{1'b0, 16'h0000, 4'b1011, 1'b0, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 16'h0000, 4'b1011, 1'b0, 1'b0, 4'h0};
    vecs[13] = '{1'b0, 16'h0000, 4'b0111, 1'b0, 1'b0, 4'h0};
    vecs[14] = '{1'b0, 16'h0000, 4'b0111, 1'b0, 1'b0, 4'h0};
    vecs[15] = '{1'b0, 16'h0000, 4'b0111, 1'b0, 1'b0, 4'h0};
    vecs[16] = '{1'b0, 16'h0000, 4'b0111, 1'b0, 1'b0, 4'h0};
    vecs[17] = '{1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0, 4'h0};

    for (int i = 0; i < 18; i++) begin
      reset   = vecs[i].rst;
      pressed = vecs[i].pressed;
      tick();
      check($sformatf("vec%0d {cols,kv,kh,key}", i),
            32'({cols, key_valid, key_held, key}),
            32'({vecs[i].cols, vecs[i].kv, vecs[i].kh, vecs[i].key}));
    end

    // Clean press of 6 (r1,c2): 4 cycles to the column sample + 8 debounce.
    wait_col(2);
    exp_q.push_back(4'h6);
    pressed[6] = 1'b1;
    wait_pulse(n);
    check("press6_latency", 32'(n), 32'd12);
    check("press6_key", 32'(key), 32'h6);
    check("press6_held", 32'(key_held), 32'd1);
    check("press6_cols_frozen", 32'(cols), 32'b1011);
    tick();
    check("press6_single_cycle_pulse", 32'(key_valid), 32'd0);
    // Release: 2 sync stages + HELD exit read + 8 debounce reads.
    pressed = '0;
    wait_held_low(n);
    check("release6_ticks", 32'(n), 32'd11);
    check("release6_next_col", 32'(cols), 32'b0111);

    // Bounce: row0 on col0 seen low for 3 debounce cycles, then high.
    wait_col(0);
    p0 = pulses;
    pressed[0] = 1'b1;
    repeat (5) tick();
    check("bounce_cols_frozen", 32'(cols), 32'b1110);
    pressed[0] = 1'b0;
    repeat (2) tick();
    check("bounce_still_col0", 32'(cols), 32'b1110);
    tick();
    check("bounce_resume_col1", 32'(cols), 32'b1101);
    repeat (12) tick();
    check("bounce_no_pulse", 32'(pulses), 32'(p0));
    check("bounce_not_held", 32'(key_held), 32'd0);

    // Key 0 (r3,c1) released with two one-cycle glitches.
    wait_col(1);
    p0 = pulses;
    exp_q.push_back(4'h0);
    pressed[13] = 1'b1;
    wait_pulse(n);
    check("press0_latency", 32'(n), 32'd12);
    check("press0_key", 32'(key), 32'h0);
    repeat (4) tick();
    pressed[13] = 1'b0;
    repeat (3) tick();
    pressed[13] = 1'b1;
    tick();
    pressed[13] = 1'b0;
    repeat (4) tick();
    pressed[13] = 1'b1;
    tick();
    pressed[13] = 1'b0;
    check("held_through_glitches", 32'(key_held), 32'd1);
    // Final glitch restarted the count: 2 sync stages + 8 clean high reads.
    wait_held_low(n);
    check("release0_ticks", 32'(n), 32'd10);
    check("release0_single_pulse", 32'(pulses), 32'(p0 + 1));

    // Rollover: hold 5 (r1,c1), then press 8 (r2,c1).
    wait_col(1);
    exp_q.push_back(4'h5);
    pressed[5] = 1'b1;
    wait_pulse(n);
    check("press5_key", 32'(key), 32'h5);
    p0 = pulses;
    pressed[9] = 1'b1;
    repeat (20) tick();
    check("rollover_key_stays", 32'(key), 32'h5);
    check("rollover_no_pulse", 32'(pulses), 32'(p0));
    check("rollover_held", 32'(key_held), 32'd1);
    pressed = '0;
    wait_held_low(n);
    check("rollover_release", 32'(key_held), 32'd0);

    // Same-column press of r0 and r2 on col0: lowest row wins.
    wait_col(0);
    exp_q.push_back(4'h1);
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    wait_pulse(n);
    check("dual_latency", 32'(n), 32'd12);
    check("lowest_row_wins", 32'(key), 32'h1);
    pressed = '0;
    wait_held_low(n);
    check("dual_release", 32'(key_held), 32'd0);

    // Reset while debouncing 9 (r2,c2) with the debounce count at 5.
    wait_col(2);
    p0 = pulses;
    pressed[10] = 1'b1;
    repeat (9) tick();
    check("reset_press_db_frozen", 32'(cols), 32'b1011);
    reset = 1'b1;
    tick();
    check("reset_mid_debounce", 32'({cols, key_valid, key_held, key}), 32'({4'b1110, 1'b0, 1'b0, 4'h0}));
    tick();
    pressed = '0;
    reset   = 1'b0;
    repeat (20) tick();
    check("reset_no_pulse", 32'(pulses), 32'(p0));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("total_pulses", 32'(pulses), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
